// File: rtl/sine_dac_sequencer.sv
// Sine-wave DAC sequencer: a phase accumulator addresses an external sine ROM.
// Samples are paced by a programmable divider and handed to the DAC over a valid/ready handshake.
module sine_dac_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 24,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_load,
  input  logic [ACC_W-1:0]  cfg_step,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  input  logic              dac_ready,
  output logic              busy,
  output logic              wrap
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PACE    = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;

  logic [2:0]        r_state;
  logic [ACC_W-1:0]  r_phase;
  logic [ACC_W-1:0]  r_step;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_stop_pend;
  logic [DATA_W-1:0] r_dac_data;
  logic              r_dac_valid;
  logic              r_wrap;

  logic              w_xfer;
  logic              w_stop_req;
  logic [ACC_W:0]    w_sum;

  assign w_xfer     = r_dac_valid & dac_ready;
  // A stop arriving in the very cycle of the transfer still ends the run there.
  assign w_stop_req = r_stop_pend | stop;
  assign w_sum      = {1'b0, r_phase} + {1'b0, r_step};

  assign rom_addr  = r_phase[ACC_W-1 -: ADDR_W];
  assign dac_data  = r_dac_data;
  assign dac_valid = r_dac_valid;
  assign busy      = (r_state != S_IDLE);
  assign wrap      = r_wrap;

  // Step/div are shadow registers: a load never disturbs an update already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
      r_div  <= '0;
    end else if (cfg_load) begin
      r_step <= cfg_step;
      r_div  <= cfg_div;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; later assignments in the same block override earlier defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (r_state != S_IDLE && stop)
        r_stop_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state <= S_PACE;
            r_cnt   <= r_div;
          end
        end
        S_PACE: begin
          if (r_cnt == '0)
            r_state <= S_FETCH;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_dac_data  <= rom_data;
          r_dac_valid <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_xfer) begin
            r_dac_valid <= 1'b0;
            r_phase     <= w_sum[ACC_W-1:0];
            r_wrap      <= w_sum[ACC_W];
            if (w_stop_req) begin
              r_state     <= S_IDLE;
              r_stop_pend <= 1'b0;
            end else begin
              r_state <= S_PACE;
              r_cnt   <= r_div;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_dac_sequencer.sv
// Scoreboard bench for sine_dac_sequencer: stimulus queues expected samples and periods,
// a negedge monitor pops and compares them on each DAC handshake.
module tb_sine_dac_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 24;
  localparam int DIV_W  = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              cfg_load;
  logic [ACC_W-1:0]  cfg_step;
  logic [DIV_W-1:0]  cfg_div;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              dac_ready;
  logic              busy;
  logic              wrap;

  sine_dac_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_load(cfg_load), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .busy(busy), .wrap(wrap)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                gap;   // expected clocks since previous transfer, 0 = unchecked
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_xfer    = 0;
  int   n_pushed  = 0;
  int   n_wrap    = 0;
  int   cyc       = 0;
  int   last_cyc  = 0;
  int   base;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input int gap);
    exp_t e;
    e.addr = a;
    e.gap  = gap;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int k = 0;
    while (n_xfer < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_xfer < target) check("xfer_timeout", n_xfer, target);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (dac_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dac_valid !== 1'b1) check("valid_timeout", dac_valid, 1);
  endtask

  // Monitor: runs on the falling edge, when DUT outputs and bench inputs are settled.
  always @(negedge clk) begin
    exp_t e;
    if (wrap === 1'b1) begin
      n_wrap++;
      check("wrap_after_256", n_xfer, 256);
    end
    if (dac_valid === 1'b1 && dac_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_xfer", n_xfer + 1, n_pushed);
      end else begin
        e = sb_q.pop_front();
        check("xfer_addr", rom_addr, e.addr);
        check("xfer_data", dac_data, rom_f(e.addr));
        if (e.gap != 0) check("xfer_period", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
      n_xfer++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
    cfg_step = '0; cfg_div = '0; dac_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", dac_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_data", dac_data, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b0;
    tick();

    // Basic sequencing and wrap: 257 samples at one per 4 clocks, addresses 0..255,0.
    cfg_step = 24'h010000; cfg_div = 16'd0; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int k = 0; k < 257; k++) push_exp(k[ADDR_W-1:0], (k == 0) ? 0 : 4);
    dac_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_xfers(257, 2000);

    // Stop during PACE: exactly one more sample.
    tick();
    check("pace_busy", busy, 1);
    push_exp(8'd1, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_xfers(258, 50);
    repeat (4) tick();
    check("stop_busy", busy, 0);

    // start+stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy0", busy, 0);
    tick();
    check("startstop_busy1", busy, 0);

    // Backpressure: phase at addr 2, step 3, div 1 (period 5).
    dac_ready = 1'b0;
    cfg_step = 24'h030000; cfg_div = 16'd1; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    push_exp(8'd2, 0);  push_exp(8'd5, 5);  push_exp(8'd8, 5);
    push_exp(8'd11, 5); push_exp(8'd14, 9); push_exp(8'd17, 9);
    base = n_xfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(50);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      check("bp_valid", dac_valid, 1);
      check("bp_data", dac_data, rom_f(8'd2));
      check("bp_addr", rom_addr, 2);
    end
    start = 1'b0;
    dac_ready = 1'b1;
    wait_xfers(base + 3, 50);

    // Live reconfiguration in PACE: current period keeps div=1, then div=5.
    tick();
    cfg_div = 16'd5; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    wait_xfers(base + 5, 60);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_xfers(base + 6, 60);
    repeat (3) tick();
    check("reconf_stop_busy", busy, 0);

    // Reset during PRESENT.
    dac_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(60);
    check("pre_rst_addr", rom_addr, 8'h14);
    check("pre_rst_data", dac_data, rom_f(8'h14));
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", dac_valid, 0);
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", dac_data, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // After reset step=0 and div=0: constant address-0 stream at period 4.
    base = n_xfer;
    push_exp(8'd0, 0);
    push_exp(8'd0, 4);
    dac_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_xfers(base + 1, 50);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_xfers(base + 2, 50);
    repeat (5) tick();
    check("final_busy", busy, 0);
    check("sb_empty", sb_q.size(), 0);
    check("wrap_count", n_wrap, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
